// File: rtl/pe_pkg.sv
// Shared defaults and saturation-limit helpers for the weight-stationary MAC PE.
// Saturation behaviour is selected by the PE_MAC_SAT_EN macro.
package pe_pkg;

    localparam int A_W_DEF   = 8;
    localparam int W_W_DEF   = 8;
    localparam int ACC_W_DEF = 24;
    localparam int PROD_W    = A_W_DEF + W_W_DEF;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_acc_add.sv
// Combinational partial-sum adder for the PE's second pipeline stage.
// With PE_MAC_SAT_EN defined it clamps to the signed ACC_W range and flags overflow.
module pe_acc_add
    import pe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

`ifdef PE_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] MIN = ACC_W'(sat_min(ACC_W));

    logic [ACC_W:0] full;

    // One guard bit: overflow iff the two top bits disagree.
    always_comb begin
        full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ovf  = full[ACC_W] ^ full[ACC_W-1];
        sum  = full[ACC_W-1:0];
        if (ovf) sum = full[ACC_W] ? MIN : MAX;
    end
`else
    assign sum = a + b;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pe_mac.sv
// Weight-stationary signed MAC PE with shadow/active weight double buffering.
// PE_MAC_SAT_EN selects saturating accumulation and a live ovf_sticky flag.
module pe_mac
    import pe_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int W_W   = W_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    w_load,
    input  logic signed [W_W-1:0]   win,
    output logic signed [W_W-1:0]   wout,
    input  logic                    w_swap,
    input  logic                    a_valid,
    input  logic signed [A_W-1:0]   ain,
    output logic                    a_valid_out,
    output logic signed [A_W-1:0]   aout,
    input  logic signed [ACC_W-1:0] psum_in,
    output logic                    psum_valid_out,
    output logic signed [ACC_W-1:0] psum_out,
    output logic                    ovf_sticky
);

    localparam int P_W = A_W + W_W;

    if (ACC_W < P_W) begin : g_width_check
        $error("pe_mac: ACC_W must be at least A_W+W_W");
    end

    logic signed [W_W-1:0]   shadow;
    logic signed [W_W-1:0]   active;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] ps1;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] sum;
    logic                    v1;
    logic                    ovf;
    logic                    ovf_q;

    // A coincident load+swap promotes the old shadow, then takes win.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (w_load) shadow <= win;
            if (w_swap) active <= shadow;
        end
    end

    assign wout = shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aout        <= '0;
            a_valid_out <= 1'b0;
        end else begin
            aout        <= ain;
            a_valid_out <= a_valid;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod <= '0;
            ps1  <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= a_valid;
            if (a_valid) begin
                prod <= P_W'(ain) * P_W'(active);
                ps1  <= psum_in;
            end
        end
    end

    assign prod_x = ACC_W'(prod);

    pe_acc_add #(
        .ACC_W(ACC_W)
    ) u_add (
        .a  (prod_x),
        .b  (ps1),
        .sum(sum),
        .ovf(ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            psum_valid_out <= v1;
            if (v1) psum_out <= sum;
            ovf_q <= ovf_q | (v1 & ovf);
        end
    end

    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_pe_mac.sv
// Randomized bench for pe_mac against an arithmetic model of the PE.
// Build with or without PE_MAC_SAT_EN to match the design.
module tb_pe_mac;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               w_load = 1'b0;
    logic signed [7:0]  win = '0;
    logic signed [7:0]  wout;
    logic               w_swap = 1'b0;
    logic               a_valid = 1'b0;
    logic signed [7:0]  ain = '0;
    logic               a_valid_out;
    logic signed [7:0]  aout;
    logic signed [23:0] psum_in = '0;
    logic               psum_valid_out;
    logic signed [23:0] psum_out;
    logic               ovf_sticky;

    int errors = 0;
    int checks = 0;

    pe_mac dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .w_load        (w_load),
        .win           (win),
        .wout          (wout),
        .w_swap        (w_swap),
        .a_valid       (a_valid),
        .ain           (ain),
        .a_valid_out   (a_valid_out),
        .aout          (aout),
        .psum_in       (psum_in),
        .psum_valid_out(psum_valid_out),
        .psum_out      (psum_out),
        .ovf_sticky    (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    typedef struct {
        bit     v;
        longint val;
        bit     ovf;
    } res_t;

    longint m_sh, m_act, m_aout, m_ps;
    bit     m_av, m_pv, m_ovf;
    res_t   q[$];

    localparam longint LIM = longint'(1) <<< 23;
    localparam longint MOD = longint'(1) <<< 24;

    function automatic res_t mac(input longint a, input longint w, input longint p);
        res_t   r;
        longint s;
        s     = p + a * w;
        r.v   = 1'b1;
        r.ovf = 1'b0;
`ifdef PE_MAC_SAT_EN
        if (s > LIM - 1) begin
            s = LIM - 1;
            r.ovf = 1'b1;
        end else if (s < -LIM) begin
            s = -LIM;
            r.ovf = 1'b1;
        end
`else
        s = ((s + LIM + 4 * MOD) % MOD) - LIM;
`endif
        r.val = s;
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        res_t e;
        if (!reset_n) begin
            m_sh = 0; m_act = 0; m_aout = 0; m_ps = 0;
            m_av = 0; m_pv = 0; m_ovf = 0;
            q.delete();
        end else begin
            if (a_valid) e = mac(ain, m_act, psum_in);
            else e = '{v: 1'b0, val: 0, ovf: 1'b0};
            q.push_back(e);
            if (q.size() == 2) begin
                e = q.pop_front();
                m_pv = e.v;
                if (e.v) begin
                    m_ps  = e.val;
                    m_ovf = m_ovf | e.ovf;
                end
            end
            if (w_swap) m_act = m_sh;
            if (w_load) m_sh = win;
            m_aout = ain;
            m_av   = a_valid;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            chk("wout", wout, m_sh);
            chk("aout", aout, m_aout);
            chk("a_valid_out", a_valid_out, m_av);
            chk("psum_valid_out", psum_valid_out, m_pv);
            chk("psum_out", psum_out, m_ps);
            chk("ovf_sticky", ovf_sticky, m_ovf);
        end
    end

    // Inputs change 2 time units after each rising edge.
    task automatic cyc(input bit wl, input int w, input bit ws,
                       input bit av, input int a, input int p);
        w_load  = wl;
        win     = 8'(w);
        w_swap  = ws;
        a_valid = av;
        ain     = 8'(a);
        psum_in = 24'(p);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            idle();
            chk("rst_psum", psum_out, 0);
            chk("rst_pvalid", psum_valid_out, 0);
            chk("rst_wout", wout, 0);
            chk("rst_aout", aout, 0);
        end

        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, -4, 100);
        chk("t2_aout", aout, -4);
        idle();
        chk("t2_psum", psum_out, 88);
        chk("t2_model", m_ps, 88);

        cyc(1, 5, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 2, 0);
        cyc(0, 0, 0, 1, 2, 0);
        chk("t3_psum_old_w", psum_out, 6);
        idle();
        chk("t3_psum_new_w", psum_out, 10);

        cyc(1, 7, 0, 0, 0, 0);
        cyc(1, 9, 1, 0, 0, 0);
        chk("t4_wout", wout, 9);
        cyc(0, 0, 0, 1, 1, 0);
        idle();
        chk("t4_active", psum_out, 7);

        cyc(1, -128, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, -128, 8388607);
        idle();
`ifdef PE_MAC_SAT_EN
        chk("t5_psum_sat", psum_out, 8388607);
        chk("t5_ovf", ovf_sticky, 1);
        repeat (3) idle();
        chk("t5_ovf_hold", ovf_sticky, 1);
`else
        chk("t5_psum_wrap", psum_out, -8372225);
        chk("t5_ovf", ovf_sticky, 0);
`endif

        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)),
                1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 255)), int'($urandom));

        for (int i = 0; i < 16; i++)
            cyc(0, 0, 0, 1, int'($urandom_range(0, 255)), int'($urandom));
        #1 reset_n = 1'b0;
        #1;
        chk("t6_pvalid_async", psum_valid_out, 0);
        chk("t6_psum_async", psum_out, 0);
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("t6_no_stale", psum_valid_out, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
